// File: rtl/mx_int8_block_dequant.sv
// MXINT8 block decoder: latches one E8M0 scale plus BLOCK_SIZE INT8
// elements and streams them out as float32 beats over valid/ready.
module mx_int8_block_dequant #(
  parameter int BLOCK_SIZE    = 32,
  parameter int SCALE_WIDTH   = 8,
  parameter int ELEM_WIDTH    = 8,
  parameter int FLOAT32_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_blk_valid,
  output logic                             o_blk_ready,
  input  logic [SCALE_WIDTH-1:0]           i_scale,
  input  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] i_elements,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [FLOAT32_WIDTH-1:0]         o_float32,
  output logic [$clog2(BLOCK_SIZE)-1:0]    o_index,
  output logic                             o_last,
  output logic                             o_overflow
);

  localparam int IW = $clog2(BLOCK_SIZE);
  localparam logic [IW-1:0] LAST = IW'(BLOCK_SIZE - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state_q, state_d;

  logic [SCALE_WIDTH-1:0] scale_q;
  logic [ELEM_WIDTH-1:0]  elem_q [BLOCK_SIZE];

  logic                   accept;
  logic                   xfer;
  logic [IW-1:0]          nidx;
  logic [SCALE_WIDTH-1:0] src_s;
  logic [ELEM_WIDTH-1:0]  src_e;
  logic [32:0]            cv;

  // Result bit 32 is the overflow flag, bits 31:0 the float32 pattern.
  function automatic logic [32:0] to_f32(
    input logic [7:0] s,
    input logic [7:0] e
  );
    logic              sgn;
    logic [7:0]        mag;
    logic [7:0]        norm;
    logic [2:0]        p;
    logic signed [9:0] ex;
    logic [32:0]       r;
    sgn = e[7];
    mag = sgn ? 8'(-e) : e;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (mag[i]) p = 3'(i);
    norm = mag << (3'd7 - p);
    ex = $signed({2'b00, s})
       + $signed({7'b0, p})
       - 10'sd6;
    if (s == 8'hFF)
      r = {1'b0, 32'h7FC0_0000};
    else if (e == 8'h00)
      r = '0;
    else if (ex >= 10'sd255)
      r = {1'b1, sgn, 8'hFF, 23'b0};
    else if (ex <= 10'sd0)
      r = {1'b0, sgn, 31'b0};
    else
      r = {1'b0, sgn, ex[7:0],
           norm[6:0], 16'b0};
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (i_blk_valid) state_d = STREAM;
      STREAM:
        if (i_ready && o_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_blk_ready = (state_q == IDLE);
    o_valid     = (state_q == STREAM);
  end

  assign accept = i_blk_valid & o_blk_ready;
  assign xfer   = o_valid & i_ready;

  // First beat decodes straight from the inputs so it appears at N+1.
  always_comb begin
    nidx  = accept ? '0 : o_index + 1'b1;
    src_s = accept ? i_scale : scale_q;
    src_e = accept ? i_elements[ELEM_WIDTH-1:0]
                   : elem_q[nidx];
    cv    = to_f32(src_s, src_e);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scale_q    <= '0;
      o_float32  <= '0;
      o_index    <= '0;
      o_last     <= 1'b0;
      o_overflow <= 1'b0;
      for (int k = 0; k < BLOCK_SIZE; k++)
        elem_q[k] <= '0;
    end else if (accept) begin
      scale_q    <= i_scale;
      o_float32  <= cv[31:0];
      o_overflow <= cv[32];
      o_index    <= '0;
      o_last     <= 1'b0;
      for (int k = 0; k < BLOCK_SIZE; k++)
        elem_q[k] <=
          i_elements[k*ELEM_WIDTH +: ELEM_WIDTH];
    end else if (xfer && !o_last) begin
      o_float32  <= cv[31:0];
      o_overflow <= cv[32];
      o_index    <= nidx;
      o_last     <= (nidx == LAST);
    end
  end

endmodule

// File: tb/tb_mx_int8_block_dequant.sv
// Directed bench for mx_int8_block_dequant: reset, decode values,
// saturation/flush boundaries, backpressure and mid-stream reset.
module tb_mx_int8_block_dequant;

  localparam int BS = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_blk_valid;
  logic          o_blk_ready;
  logic [7:0]    i_scale;
  logic [BS*8-1:0] i_elements;
  logic          o_valid;
  logic          i_ready;
  logic [31:0]   o_float32;
  logic [4:0]    o_index;
  logic          o_last;
  logic          o_overflow;

  int n_chk  = 0;
  int n_fail = 0;

  logic [BS*8-1:0] elems;
  logic [31:0] exp_f [BS];
  logic        exp_o [BS];
  logic [31:0] got_f [64];
  logic [4:0]  got_i [64];
  logic        got_l [64];
  logic        got_o [64];
  int          n_got;
  int          cycles;
  logic        done;

  always #5 clk = ~clk;

  mx_int8_block_dequant dut (
    .clk         (clk),
    .rst         (rst),
    .i_blk_valid (i_blk_valid),
    .o_blk_ready (o_blk_ready),
    .i_scale     (i_scale),
    .i_elements  (i_elements),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_float32   (o_float32),
    .o_index     (o_index),
    .o_last      (o_last),
    .o_overflow  (o_overflow)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Called at a negedge while the DUT is idle.
  task automatic send(input logic [7:0] s);
    chk("blk_ready_idle", 32'(o_blk_ready), 1);
    i_scale     = s;
    i_elements  = elems;
    i_blk_valid = 1'b1;
    @(negedge clk);
    i_blk_valid = 1'b0;
    i_scale     = ~s;
    i_elements  = ~elems;
    chk("first_valid", 32'(o_valid), 1);
    chk("first_index", 32'(o_index), 0);
    chk("blk_ready_busy", 32'(o_blk_ready), 0);
  endtask

  task automatic stream(input bit rnd);
    logic        pend;
    logic        r;
    logic [31:0] hf;
    logic [4:0]  hi;
    pend   = 1'b0;
    n_got  = 0;
    cycles = 0;
    done   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (pend) begin
        chk("hold_valid", 32'(o_valid), 1);
        chk("hold_float", o_float32, hf);
        chk("hold_index", 32'(o_index), 32'(hi));
        pend = 1'b0;
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_ready = r;
      if (o_valid && r && n_got < 64) begin
        got_f[n_got] = o_float32;
        got_i[n_got] = o_index;
        got_l[n_got] = o_last;
        got_o[n_got] = o_overflow;
        n_got++;
        if (o_last) done = 1'b1;
      end else if (o_valid) begin
        pend = 1'b1;
        hf   = o_float32;
        hi   = o_index;
      end
      cycles++;
      @(negedge clk);
      if (done) break;
    end
    i_ready = 1'b0;
    chk("stream_done", 32'(done), 1);
    chk("idle_valid", 32'(o_valid), 0);
    chk("idle_ready", 32'(o_blk_ready), 1);
  endtask

  task automatic check_block(input string nm);
    chk({nm, "_beats"}, n_got, BS);
    for (int k = 0; k < BS && k < n_got; k++) begin
      chk({nm, "_float"}, got_f[k], exp_f[k]);
      chk({nm, "_index"}, 32'(got_i[k]), k);
      chk({nm, "_last"}, 32'(got_l[k]),
          (k == BS - 1) ? 1 : 0);
      chk({nm, "_ovf"}, 32'(got_o[k]),
          32'(exp_o[k]));
    end
  endtask

  task automatic fill(input logic [7:0] e,
                      input logic [31:0] f);
    for (int k = 0; k < BS; k++) begin
      elems[k*8 +: 8] = e;
      exp_f[k] = f;
      exp_o[k] = 1'b0;
    end
  endtask

  initial begin
    rst         = 1'b1;
    i_blk_valid = 1'b0;
    i_ready     = 1'b0;
    i_scale     = '0;
    i_elements  = '0;
    elems       = '0;
    repeat (3) @(negedge clk);
    chk("rst_blk_ready", 32'(o_blk_ready), 1);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_float", o_float32, 0);
    chk("rst_index", 32'(o_index), 0);
    chk("rst_last", 32'(o_last), 0);
    chk("rst_ovf", 32'(o_overflow), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1.0 everywhere, full throughput
    fill(8'h40, 32'h3F80_0000);
    send(8'd127);
    stream(1'b0);
    check_block("ones");
    chk("ones_cycles", cycles, BS);

    // sign, tiny, zero, max mantissa, negative
    fill(8'h00, 32'h0000_0000);
    elems[0*8 +: 8] = 8'h80; exp_f[0] = 32'hC000_0000;
    elems[1*8 +: 8] = 8'h01; exp_f[1] = 32'h3C80_0000;
    elems[3*8 +: 8] = 8'h7F; exp_f[3] = 32'h3FFE_0000;
    elems[4*8 +: 8] = 8'hC0; exp_f[4] = 32'hBF80_0000;
    send(8'd127);
    stream(1'b1);
    check_block("mix");

    // NaN scale
    fill(8'h00, 32'h7FC0_0000);
    for (int k = 0; k < BS; k++)
      elems[k*8 +: 8] = 8'(k * 37 + 5);
    send(8'hFF);
    stream(1'b1);
    check_block("nan");

    // saturation at the top of the exponent range
    fill(8'h00, 32'h0000_0000);
    elems[0*8 +: 8] = 8'h80;
    exp_f[0] = 32'hFF80_0000; exp_o[0] = 1'b1;
    elems[1*8 +: 8] = 8'h40; exp_f[1] = 32'h7F00_0000;
    elems[2*8 +: 8] = 8'h01; exp_f[2] = 32'h7C00_0000;
    send(8'd254);
    stream(1'b1);
    check_block("ovf");

    // flush at the bottom of the exponent range
    fill(8'h00, 32'h0000_0000);
    elems[0*8 +: 8] = 8'h01; exp_f[0] = 32'h0000_0000;
    elems[1*8 +: 8] = 8'h81; exp_f[1] = 32'h8000_0000;
    elems[2*8 +: 8] = 8'h40; exp_f[2] = 32'h0000_0000;
    elems[3*8 +: 8] = 8'h80; exp_f[3] = 32'h8080_0000;
    send(8'd0);
    stream(1'b1);
    check_block("flush");

    // reset while beat 10 is presented
    fill(8'h40, 32'h3F80_0000);
    send(8'd127);
    i_ready = 1'b1;
    repeat (10) @(negedge clk);
    i_ready = 1'b0;
    chk("pre_rst_index", 32'(o_index), 10);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 0);
    chk("mid_rst_ready", 32'(o_blk_ready), 1);
    chk("mid_rst_index", 32'(o_index), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(o_valid), 0);
    fill(8'h40, 32'h4000_0000);
    send(8'd128);
    stream(1'b1);
    check_block("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
